// File: rtl/dwconv1d_pkg.sv
// ----------------------------------------------------------------------------
// dwconv1d_pkg : shared types and constants for the dwconv1d job scheduler
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dwconv1d_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_e;

  localparam int NREQ_DEF           = 4;
  localparam int REQ_ID_W           = $clog2(NREQ_DEF);
  localparam int TILE_W_DEF         = 4;
  // C * LOUT * K for the nominal layer shape; benches use it as engine latency
  localparam int ENG_NOMINAL_CYCLES = 168;

endpackage

`default_nettype wire

// File: rtl/dwconv1d_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick, searching upward from ptr
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import dwconv1d_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int ID_W = REQ_ID_W
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [ID_W-1:0] win_idx,
  output logic            any
);

  logic            w_found;
  logic [ID_W-1:0] w_j;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = ID_W'((int'(ptr) + k) % NREQ);
      if (!w_found && req[w_j]) begin
        w_found     = 1'b1;
        win_oh[w_j] = 1'b1;
        win_idx     = w_j;
      end
    end
  end

  assign any = |req;

endmodule

`default_nettype wire

// File: rtl/dwconv1d_sched.sv
// ----------------------------------------------------------------------------
// dwconv1d_sched : round-robin job scheduler sharing one dwconv1d engine
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dwconv1d_sched
  import dwconv1d_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int TILE_W  = TILE_W_DEF,
  parameter int TIMEOUT = 512
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*TILE_W-1:0]   req_tiles,
  output logic [NREQ-1:0]          gnt,
  output logic                     eng_start,
  output logic [TILE_W-1:0]        eng_tile,
  output logic [$clog2(NREQ)-1:0]  eng_owner,
  input  logic                     eng_done,
  output logic                     eng_abort,
  output logic                     resp_valid,
  output logic [$clog2(NREQ)-1:0]  resp_id,
  output logic                     resp_err,
  input  logic                     resp_ready
);

  localparam int c_id_w = $clog2(NREQ);
  localparam int c_wd_w = $clog2(TIMEOUT + 1);
  localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT - 1);
  localparam logic [c_id_w-1:0] c_id_last = c_id_w'(NREQ - 1);

  sched_state_e r_state, w_state;

  logic [c_id_w-1:0] r_rr_ptr, w_rr_ptr;
  logic [c_id_w-1:0] r_owner, w_owner;
  logic [TILE_W-1:0] r_tiles, w_tiles;
  logic [TILE_W-1:0] r_cur, w_cur;
  logic [c_wd_w-1:0] r_wdog, w_wdog;
  logic              r_err, w_err;
  logic [NREQ-1:0]   r_gnt, w_gnt;
  logic              r_eng_start, w_eng_start;
  logic [TILE_W-1:0] r_eng_tile, w_eng_tile;
  logic              r_eng_abort, w_eng_abort;
  logic              r_resp_valid, w_resp_valid;
  logic [c_id_w-1:0] r_resp_id, w_resp_id;
  logic              r_resp_err, w_resp_err;

  logic [NREQ-1:0]   w_win_oh;
  logic [c_id_w-1:0] w_win_idx;
  logic              w_any;
  logic [TILE_W-1:0] w_sel_tiles;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (c_id_w)
  ) u_arb (
    .req     (req),
    .ptr     (r_rr_ptr),
    .win_oh  (w_win_oh),
    .win_idx (w_win_idx),
    .any     (w_any)
  );

  always_comb begin
    w_sel_tiles = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win_oh[i]) w_sel_tiles = w_sel_tiles | req_tiles[i*TILE_W +: TILE_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state;
  end

  always_comb begin
    w_state      = r_state;
    w_rr_ptr     = r_rr_ptr;
    w_owner      = r_owner;
    w_tiles      = r_tiles;
    w_cur        = r_cur;
    w_wdog       = r_wdog;
    w_err        = r_err;
    w_gnt        = '0;
    w_eng_start  = 1'b0;
    w_eng_tile   = r_eng_tile;
    w_eng_abort  = 1'b0;
    w_resp_valid = r_resp_valid;
    w_resp_id    = r_resp_id;
    w_resp_err   = r_resp_err;

    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_gnt   = w_win_oh;
          w_owner = w_win_idx;
          w_tiles = w_sel_tiles;
          w_cur   = '0;
          w_err   = 1'b0;
          w_state = (w_sel_tiles == '0) ? RESP : START;
        end
      end
      START: begin
        w_eng_start = 1'b1;
        w_eng_tile  = r_cur;
        w_wdog      = '0;
        w_state     = WAIT;
      end
      WAIT: begin
        w_wdog = r_wdog + c_wd_w'(1);
        if (eng_done) begin
          if (r_cur == r_tiles - TILE_W'(1)) begin
            w_err   = 1'b0;
            w_state = RESP;
          end else begin
            // Next tile is launched straight from here so start trails done by one cycle
            w_cur       = r_cur + TILE_W'(1);
            w_eng_start = 1'b1;
            w_eng_tile  = r_cur + TILE_W'(1);
            w_wdog      = '0;
          end
        end else if (r_wdog == c_wd_last) begin
          w_eng_abort = 1'b1;
          w_err       = 1'b1;
          w_state     = RESP;
        end
      end
      RESP: begin
        if (!r_resp_valid) begin
          w_resp_valid = 1'b1;
          w_resp_id    = r_owner;
          w_resp_err   = r_err;
        end else if (resp_ready) begin
          w_resp_valid = 1'b0;
          w_rr_ptr     = (r_owner == c_id_last) ? '0 : r_owner + c_id_w'(1);
          w_state      = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr     <= '0;
      r_owner      <= '0;
      r_tiles      <= '0;
      r_cur        <= '0;
      r_wdog       <= '0;
      r_err        <= 1'b0;
      r_gnt        <= '0;
      r_eng_start  <= 1'b0;
      r_eng_tile   <= '0;
      r_eng_abort  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_rr_ptr     <= w_rr_ptr;
      r_owner      <= w_owner;
      r_tiles      <= w_tiles;
      r_cur        <= w_cur;
      r_wdog       <= w_wdog;
      r_err        <= w_err;
      r_gnt        <= w_gnt;
      r_eng_start  <= w_eng_start;
      r_eng_tile   <= w_eng_tile;
      r_eng_abort  <= w_eng_abort;
      r_resp_valid <= w_resp_valid;
      r_resp_id    <= w_resp_id;
      r_resp_err   <= w_resp_err;
    end
  end

  assign gnt        = r_gnt;
  assign eng_start  = r_eng_start;
  assign eng_tile   = r_eng_tile;
  assign eng_owner  = r_owner;
  assign eng_abort  = r_eng_abort;
  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_err   = r_resp_err;

endmodule

`default_nettype wire

// File: tb/tb_dwconv1d_sched.sv
// ----------------------------------------------------------------------------
// tb_dwconv1d_sched : randomized self-checking bench for dwconv1d_sched
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dwconv1d_sched;

  localparam int NREQ    = 4;
  localparam int TILE_W  = 4;
  localparam int TIMEOUT = 512;
  localparam int IDW     = 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ*TILE_W-1:0] req_tiles = '0;
  logic                   resp_ready = 1'b0;
  logic [NREQ-1:0]        gnt;
  logic                   eng_start;
  logic [TILE_W-1:0]      eng_tile;
  logic [IDW-1:0]         eng_owner;
  logic                   eng_done;
  logic                   eng_abort;
  logic                   resp_valid;
  logic [IDW-1:0]         resp_id;
  logic                   resp_err;

  logic eng_fin  = 1'b0;
  logic inj_done = 1'b0;
  assign eng_done = eng_fin | inj_done;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int m_ptr   = 0;
  int eng_lat = 4;
  bit eng_en  = 1'b1;

  dwconv1d_sched #(
    .NREQ    (NREQ),
    .TILE_W  (TILE_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_tiles  (req_tiles),
    .gnt        (gnt),
    .eng_start  (eng_start),
    .eng_tile   (eng_tile),
    .eng_owner  (eng_owner),
    .eng_done   (eng_done),
    .eng_abort  (eng_abort),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_err   (resp_err),
    .resp_ready (resp_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: done pulse eng_lat cycles after each observed start
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        cnt     = 0;
        eng_fin = 1'b0;
      end else begin
        eng_fin = 1'b0;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) eng_fin = 1'b1;
        end
        if (eng_start && eng_en) cnt = eng_lat;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({gnt, eng_start, eng_tile, eng_owner, eng_abort, resp_valid, resp_id, resp_err});
  endfunction

  function automatic int pick(input logic [NREQ-1:0] m, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ*TILE_W-1:0] pack(input int t0, input int t1, input int t2, input int t3);
    return {TILE_W'(t3), TILE_W'(t2), TILE_W'(t1), TILE_W'(t0)};
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
  endtask

  // Raise every requester in mask, then follow each granted job to its response
  task automatic run_batch(input logic [NREQ-1:0] mask, input logic [NREQ*TILE_W-1:0] tl,
                           input int lat, input bit en, input int rdy);
    logic [NREQ-1:0] pend;
    logic [IDW-1:0]  rid;
    logic            rerr;
    int w, n, ntile, exp_tile, last_done, start_cyc, gnt_cyc, k, budget;
    int extra, unstable, starts, aborts, exp_starts;
    bit got_resp;
    pend = mask;
    req_tiles = tl;
    eng_lat = lat;
    eng_en = en;
    req = mask;
    while (pend != '0) begin
      w = pick(pend, m_ptr);
      n = 0;
      while (gnt == '0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("gnt", 32'(gnt), 32'(1 << w));
      if (gnt == '0) begin
        req = '0;
        return;
      end
      gnt_cyc = cyc;
      req[w] = 1'b0;
      pend[w] = 1'b0;
      ntile = int'(tl[w*TILE_W +: TILE_W]);
      exp_tile = 0; last_done = -1; start_cyc = -1; extra = 0; unstable = 0;
      starts = 0; aborts = 0; got_resp = 1'b0; k = 0;
      rid = 'x; rerr = 1'bx;
      budget = TIMEOUT + ntile * (lat + 4) + rdy + 40;
      while (!got_resp && budget > 0) begin
        @(negedge clk);
        budget--;
        if (gnt != '0) extra++;
        if (eng_start) begin
          chk("tile", 32'(eng_tile), 32'(exp_tile));
          chk("owner", 32'(eng_owner), 32'(w));
          chk("start_gap", 32'(cyc - ((exp_tile == 0) ? gnt_cyc : last_done)), 32'd1);
          start_cyc = cyc;
          exp_tile++;
          starts++;
        end
        if (eng_done) last_done = cyc;
        if (eng_abort) begin
          aborts++;
          chk("abort_lat", 32'(cyc - start_cyc), 32'(TIMEOUT));
        end
        if (resp_valid) begin
          if (k == 0) begin
            rid = resp_id;
            rerr = resp_err;
          end else if (resp_id !== rid || resp_err !== rerr) begin
            unstable++;
          end
          if (k == rdy) begin
            resp_ready = 1'b1;
            got_resp = 1'b1;
          end
          k++;
        end
      end
      chk("resp_seen", 32'(got_resp), 32'd1);
      @(negedge clk);
      resp_ready = 1'b0;
      chk("resp_drop", 32'(resp_valid), 32'd0);
      exp_starts = (ntile == 0) ? 0 : (en ? ntile : 1);
      chk("starts", 32'(starts), 32'(exp_starts));
      chk("aborts", 32'(aborts), 32'((!en && ntile > 0) ? 1 : 0));
      chk("resp_id", 32'(rid), 32'(w));
      chk("resp_err", 32'(rerr), 32'((!en && ntile > 0) ? 1 : 0));
      chk("busy_gnt", 32'(extra), 32'd0);
      chk("resp_stable", 32'(unstable), 32'd0);
      m_ptr = (w + 1) % NREQ;
    end
  endtask

  initial begin
    int n, st, quiet_bad;
    repeat (3) @(negedge clk);
    chk("rst_outs", outs(), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outs", outs(), 32'd0);
    m_ptr = 0;

    run_batch(4'b0001, pack(3, 0, 0, 0), 168, 1'b1, 0);

    pulse_reset();
    run_batch(4'b0101, pack(1, 0, 1, 0), int'($urandom_range(3, 10)), 1'b1, 0);
    run_batch(4'b0101, pack(1, 0, 1, 0), int'($urandom_range(3, 10)), 1'b1, 0);

    run_batch(4'b0001, pack(2, 0, 0, 0), 4, 1'b0, 0);
    run_batch(4'b0010, pack(0, 0, 0, 0), 4, 1'b1, 0);
    run_batch(4'b0100, pack(0, 0, 15, 0), 2, 1'b1, 1);
    run_batch(4'b1010, pack(0, 1, 0, 1), 3, 1'b1, 10);

    // Reset in the middle of tile 1 of a three-tile job
    req_tiles = pack(0, 0, 0, 3);
    eng_lat = 20;
    eng_en = 1'b1;
    req = 4'b1000;
    n = 0;
    while (gnt == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("gnt_rst_job", 32'(gnt), 32'b1000);
    req = '0;
    n = 0;
    st = 0;
    while (st < 2 && n < 200) begin
      @(negedge clk);
      n++;
      if (eng_start) st++;
    end
    chk("tile1_started", 32'(st), 32'd2);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", outs(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    quiet_bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      inj_done = (i == 2);
      if (resp_valid || eng_start || eng_abort || gnt != '0) quiet_bad++;
    end
    inj_done = 1'b0;
    chk("post_rst_quiet", 32'(quiet_bad), 32'd0);
    run_batch(4'b1010, pack(0, 1, 0, 1), 5, 1'b1, 0);

    for (int b = 0; b < 12; b++) begin
      logic [NREQ-1:0]        mk;
      logic [NREQ*TILE_W-1:0] tv;
      mk = NREQ'($urandom_range(1, 15));
      tv = (NREQ*TILE_W)'($urandom & 32'h3333);
      run_batch(mk, tv, int'($urandom_range(1, 12)), 1'b1, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: cycle %0d reached without finishing", cyc);
    $fatal(1, "bench time limit expired");
  end

endmodule

`default_nettype wire

// File: doc/dwconv1d_sched.md
Name: dwconv1d_sched

Overview:
Job scheduler that shares one dwconv1d INT8 engine (channel-tile granularity, start/done handshake) between NREQ requesters. It performs round-robin arbitration and sequences each granted job as a run of per-tile engine starts. It also watchdogs each engine run and returns one completion response per job. It sits between the layer-level control logic and the single depthwise-conv engine instance.

Parameters:
NREQ, 4, number of requesters (2..8)
TILE_W, 4, width of per-job tile count and tile index
TIMEOUT, 512, max cycles from eng_start to eng_done before abort (engine nominal run C*LOUT*K = 168)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  level request per requester; held until matching gnt
req_tiles  in  NREQ*TILE_W  tile count per requester, sampled at grant
gnt  out  NREQ  one-hot, one-cycle grant pulse
eng_start  out  1  one-cycle start pulse to engine
eng_tile  out  TILE_W  tile index for current run, stable from eng_start until eng_done or abort
eng_owner  out  $clog2(NREQ)  current job owner id
eng_done  in  1  one-cycle engine completion pulse
eng_abort  out  1  one-cycle pulse on watchdog expiry
resp_valid  out  1  job response valid
resp_id  out  $clog2(NREQ)  owner of completed job
resp_err  out  1  1 = job aborted by watchdog
resp_ready  in  1  response accept

Behaviour:
- All outputs registered. On rst_n low, asynchronously: state=IDLE, rr_ptr=0, all outputs 0, counters 0.
- States: IDLE, START, WAIT, RESP.
- IDLE: if |req, pick first set bit searching from rr_ptr upward with wrap. Next cycle: gnt[w]=1, owner=w, tiles=req_tiles[w], cur_tile=0. If tiles==0, go to RESP with err=0 and issue no engine start. Otherwise go to START.
- START: eng_start=1 for one cycle, eng_tile=cur_tile, wdog=0, then WAIT. Minimum latency from req to eng_start is 2 cycles.
- WAIT: wdog increments each cycle.
  - On eng_done with cur_tile==tiles-1: go to RESP, err=0.
  - On eng_done otherwise: cur_tile+1, go to START. eng_start follows done by exactly 1 cycle.
  - If wdog==TIMEOUT-1 and no eng_done: eng_abort=1 for one cycle, go to RESP, err=1. Remaining tiles are skipped.
  - If eng_done and expiry occur in the same cycle, done wins and no abort is issued.
- RESP: resp_valid=1 with resp_id=owner and resp_err held stable until resp_ready is sampled high. On that cycle: resp_valid falls next cycle, rr_ptr=(owner+1) mod NREQ, go to IDLE. No arbitration or grant occurs while in RESP.
- eng_done outside WAIT is ignored.
- req changes outside IDLE are ignored.
- A req dropped before gnt is legal.
- A req still high after its own response re-enters arbitration normally, at lowest priority.
- req_tiles beyond the tile count is not checked; the full TILE_W range is honoured.
- Reset mid-job drops the job with no response. The engine must be reset by the same rst_n.

Decomposition:
- Package dwconv1d_pkg: sched_state_e enum, REQ_ID_W=$clog2(NREQ), TILE_W default, engine nominal cycle count constant for benches.
- Sub-module rr_arbiter: NREQ-wide round-robin pick.
  - Inputs: req, rr_ptr.
  - Outputs: one-hot winner and index, combinational.
- FSM, tile counter and watchdog stay in dwconv1d_sched.

Test Plan:
- req=0001, tiles=3, engine model done 168 cycles after each start -> eng_start with eng_tile 0,1,2; each start exactly 1 cycle after prior done; one resp id=0 err=0.
- req=0101 together after reset, tiles=1 each, resp_ready=1 -> gnt0 then gnt2. Re-raise both -> gnt0 (rr_ptr=3 wraps to 0).
- req=0010, tiles=0 -> gnt1, resp id=1 err=0 two cycles later; eng_start never asserted.
- Engine never responds, TIMEOUT=512 -> eng_abort exactly 512 cycles after eng_start; resp err=1; tile 1 never started.
- resp_ready low for 10 cycles with req1 pending -> resp_valid and fields stable, no gnt; gnt1 follows ready.
- rst_n pulsed low in WAIT at tile 1 -> outputs 0 immediately. After release: IDLE, rr_ptr=0, no resp; a stray eng_done is ignored.
